simt_div_stack: RTL and testbench
=================================

# simt_div_stack

Parametrised, multi-warp SIMT divergence stack for the SM core scheduler. It keeps one predicate-mask stack per warp. Each entry carries an active mask, a don't-care mask and an optional reconvergence PC. The issue stage drives PUSH/POP/COMP/INIT operations to one warp per cycle. The block reports the queried warp's top-of-stack plus all-true/all-false branch-uniformity flags, so the scheduler can skip uniform branches.

## Interface
- N_LANES, 4, lanes per warp (mask width)
- DEPTH, 8, entries per warp stack including the base entry (≥2)
- N_WARPS, 2, independent stacks
- PC_W, 16, reconvergence PC width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- op_valid  in  1  operation strobe
- op_code  in  2  00 PUSH, 01 POP, 10 COMP, 11 INIT
- op_warp  in  $clog2(N_WARPS)  target warp
- op_mask  in  N_LANES  branch-taken mask (PUSH) / initial mask (INIT)
- op_rpc  in  PC_W  reconvergence PC (PUSH)
- q_warp  in  $clog2(N_WARPS)  status query select
- q_pc  in  PC_W  current PC of queried warp
- tos_mask  out  N_LANES  queried warp top mask
- tos_rpc  out  PC_W  queried warp top RPC
- level  out  $clog2(DEPTH)  queried warp stack pointer
- all_true, all_false  out  1  uniformity flags
- reconv  out  1  q_pc equals top RPC and level>0
- overflow, underflow  out  N_WARPS  sticky per-warp error flags

## Operation
- Per-warp state: ptr (0..DEPTH-1) and entries {mask, dc, rpc}.
- Reset or INIT sets ptr=0 and base entry mask=all ones (reset) or op_mask (INIT), dc=0, rpc=0.
- INIT also clears that warp's error flags.
- Let P be the parent (top) entry.
- PUSH: ptr+1; new entry mask = op_mask & P.mask & ~P.dc; dc = P.dc | ~P.mask; rpc = op_rpc.
- POP: ptr−1.
- COMP: top mask = ~mask & ~dc. dc and rpc are unchanged.
- all_true = ((mask | dc) == all ones).
- all_false = ((mask & ~dc) == 0).
- Both flags are evaluated on the queried top entry.
- Boundaries:
  - PUSH at ptr=DEPTH-1: ignored, overflow[w] set.
  - POP at ptr=0: ignored, underflow[w] set.
  - COMP at ptr=0: ignored, underflow[w] set.
- Operations on one warp never disturb another warp's state.
- op_valid=0 means no state change.

## Timing
- All state updates on posedge clk; one operation per cycle; no backpressure.
- Status outputs are combinational reads of registered state selected by q_warp and q_pc.
- An operation issued in cycle N is visible on the outputs from cycle N+1.
- If q_warp = op_warp in the same cycle, the outputs show the pre-operation state.
- Reset values with q_warp=0: tos_mask=all ones, tos_rpc=0, level=0, all_true=1, all_false=0, reconv=0, overflow=underflow=0.
- Reset asserted mid-sequence returns every warp to the base state immediately, asynchronously.

## Configuration
- DIVSTACK_RPC_EN defined: rpc fields are stored; tos_rpc and reconv are driven as above.
- DIVSTACK_RPC_EN undefined: no rpc storage; op_rpc and q_pc are ignored; tos_rpc=0 and reconv=0 constantly.

## Structure
- Shared package divstack_pkg:
  - divstack_op_e enum (PUSH/POP/COMP/INIT)
  - divstack_entry_t struct {mask, dc, rpc}, parametrised through the package constants N_LANES and PC_W
- Sub-module divstack_warp holds one warp's stack, ptr, error flags and flag logic. It is instantiated N_WARPS times with a per-warp op enable.
- The top level decodes op_warp and muxes status outputs by q_warp.

## Test plan
- Reset → q_warp=0,1 both show tos_mask=4'b1111, level=0, all_true=1, all_false=0.
- Warp0 PUSH op_mask=4'b0011, rpc=0x40 → next cycle tos_mask=0011, level=1, all_true=0, all_false=0; q_pc=0x40 gives reconv=1; warp1 unchanged.
- Warp0 nested PUSH 4'b0001, COMP, POP, POP:
  - after PUSH: tos_mask=0001, dc=1100
  - after COMP: tos_mask=0010
  - after the two POPs: level=0, tos_mask=1111
- Warp0 PUSH op_mask=4'b1111 under parent 0011 → all_true=1. A following COMP gives mask 0000 and all_false=1.
- Overflow and underflow on warp1:
  - 8 PUSHes: level saturates at 7 and overflow[1]=1 after the 8th.
  - POP at level 0: underflow[1]=1.
  - INIT: both flags clear.
- Reset asserted between two ops at level 3 → outputs return to their reset values without a clock edge; the next PUSH yields level=1.

Source files
------------

// File: rtl/divstack_pkg.sv
// Shared types for the SIMT divergence stack: operation codes and the stack entry layout.
// Entry widths come from N_LANES and PC_W below; the top-level parameters must match them.
package divstack_pkg;

  localparam int N_LANES = 4;
  localparam int PC_W    = 16;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_COMP = 2'b10,
    OP_INIT = 2'b11
  } divstack_op_e;

  typedef struct packed {
    logic [N_LANES-1:0] mask;
    logic [N_LANES-1:0] dc;
    logic [PC_W-1:0]    rpc;
  } divstack_entry_t;

endpackage

// File: rtl/divstack_warp.sv
// One warp's predicate-mask stack: pointer, sticky error flags and uniformity flags.
// The RPC storage and reconvergence compare exist only when DIVSTACK_RPC_EN is defined.
module divstack_warp
  import divstack_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int LVL_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  divstack_op_e       op_code,
  input  logic [N_LANES-1:0] op_mask,
  input  logic [PC_W-1:0]    op_rpc,
  input  logic [PC_W-1:0]    q_pc,
  output logic [N_LANES-1:0] tos_mask,
  output logic [PC_W-1:0]    tos_rpc,
  output logic [LVL_W-1:0]   level,
  output logic               all_true,
  output logic               all_false,
  output logic               reconv,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] ONE     = LVL_W'(1);

  divstack_entry_t  base_q;
  divstack_entry_t  stk_q [1:DEPTH-1];
  logic [LVL_W-1:0] ptr_q;
  logic             ovf_q;
  logic             unf_q;

  divstack_entry_t  top;
  divstack_entry_t  child;
  logic             do_push;
  logic             do_comp;

  // Entry 0 lives in base_q so only it needs a reset value; deeper entries are
  // always written by a PUSH before the pointer can reach them.
  always_comb begin
    top = base_q;
    if (ptr_q != '0) top = stk_q[ptr_q];
  end

  always_comb begin
    child.mask = op_mask & top.mask & ~top.dc;
    child.dc   = top.dc | ~top.mask;
`ifdef DIVSTACK_RPC_EN
    child.rpc  = op_rpc;
`else
    child.rpc  = '0;
`endif
  end

  assign do_push = en && (op_code == OP_PUSH) && (ptr_q != TOP_LVL);
  assign do_comp = en && (op_code == OP_COMP) && (ptr_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      base_q <= '{mask: '1, dc: '0, rpc: '0};
    end else if (en) begin
      unique case (op_code)
        OP_PUSH: begin
          if (ptr_q == TOP_LVL) ovf_q <= 1'b1;
          else                  ptr_q <= ptr_q + ONE;
        end
        OP_POP: begin
          if (ptr_q == '0) unf_q <= 1'b1;
          else             ptr_q <= ptr_q - ONE;
        end
        OP_COMP: begin
          if (ptr_q == '0) unf_q <= 1'b1;
        end
        OP_INIT: begin
          ptr_q  <= '0;
          ovf_q  <= 1'b0;
          unf_q  <= 1'b0;
          base_q <= '{mask: op_mask, dc: '0, rpc: '0};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) stk_q[ptr_q + ONE] <= child;
    if (do_comp) stk_q[ptr_q].mask <= ~top.mask & ~top.dc;
  end

  assign tos_mask  = top.mask;
  assign level     = ptr_q;
  assign all_true  = &(top.mask | top.dc);
  assign all_false = ~|(top.mask & ~top.dc);
  assign overflow  = ovf_q;
  assign underflow = unf_q;

`ifdef DIVSTACK_RPC_EN
  assign tos_rpc = top.rpc;
  assign reconv  = (ptr_q != '0) && (q_pc == top.rpc);
`else
  logic unused_rpc;
  assign unused_rpc = ^{op_rpc, q_pc, top.rpc};
  assign tos_rpc    = '0;
  assign reconv     = 1'b0;
`endif

endmodule

// File: rtl/simt_div_stack.sv
// Multi-warp SIMT divergence stack: decodes op_warp into per-warp enables and muxes status by q_warp.
// Define DIVSTACK_RPC_EN to store reconvergence PCs and drive tos_rpc/reconv.
module simt_div_stack
  import divstack_pkg::*;
#(
  parameter  int N_LANES = divstack_pkg::N_LANES,
  parameter  int DEPTH   = 8,
  parameter  int N_WARPS = 2,
  parameter  int PC_W    = divstack_pkg::PC_W,
  localparam int WARP_W  = (N_WARPS > 1) ? $clog2(N_WARPS) : 1,
  localparam int LVL_W   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [1:0]         op_code,
  input  logic [WARP_W-1:0]  op_warp,
  input  logic [N_LANES-1:0] op_mask,
  input  logic [PC_W-1:0]    op_rpc,
  input  logic [WARP_W-1:0]  q_warp,
  input  logic [PC_W-1:0]    q_pc,
  output logic [N_LANES-1:0] tos_mask,
  output logic [PC_W-1:0]    tos_rpc,
  output logic [LVL_W-1:0]   level,
  output logic               all_true,
  output logic               all_false,
  output logic               reconv,
  output logic [N_WARPS-1:0] overflow,
  output logic [N_WARPS-1:0] underflow
);

  divstack_op_e       op_e;
  logic [N_LANES-1:0] mask_w [N_WARPS];
  logic [PC_W-1:0]    rpc_w  [N_WARPS];
  logic [LVL_W-1:0]   lvl_w  [N_WARPS];
  logic [N_WARPS-1:0] at_w;
  logic [N_WARPS-1:0] af_w;
  logic [N_WARPS-1:0] rc_w;

  assign op_e = divstack_op_e'(op_code);

  for (genvar w = 0; w < N_WARPS; w++) begin : g_warp
    divstack_warp #(.DEPTH(DEPTH)) u_warp (
      .clk       (clk),
      .reset     (reset),
      .en        (op_valid && (op_warp == WARP_W'(w))),
      .op_code   (op_e),
      .op_mask   (op_mask),
      .op_rpc    (op_rpc),
      .q_pc      (q_pc),
      .tos_mask  (mask_w[w]),
      .tos_rpc   (rpc_w[w]),
      .level     (lvl_w[w]),
      .all_true  (at_w[w]),
      .all_false (af_w[w]),
      .reconv    (rc_w[w]),
      .overflow  (overflow[w]),
      .underflow (underflow[w])
    );
  end

  assign tos_mask  = mask_w[q_warp];
  assign tos_rpc   = rpc_w[q_warp];
  assign level     = lvl_w[q_warp];
  assign all_true  = at_w[q_warp];
  assign all_false = af_w[q_warp];
  assign reconv    = rc_w[q_warp];

endmodule

// File: tb/tb_simt_div_stack.sv
// Bench for simt_div_stack: directed scenarios plus random ops checked against a queue-based stack model.
module tb_simt_div_stack;

  localparam int N_LANES = 4;
  localparam int DEPTH   = 8;
  localparam int N_WARPS = 2;
  localparam int PC_W    = 16;
`ifdef DIVSTACK_RPC_EN
  localparam bit RPC_EN = 1'b1;
`else
  localparam bit RPC_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               op_valid;
  logic [1:0]         op_code;
  logic [0:0]         op_warp;
  logic [N_LANES-1:0] op_mask;
  logic [PC_W-1:0]    op_rpc;
  logic [0:0]         q_warp;
  logic [PC_W-1:0]    q_pc;
  logic [N_LANES-1:0] tos_mask;
  logic [PC_W-1:0]    tos_rpc;
  logic [2:0]         level;
  logic               all_true, all_false, reconv;
  logic [N_WARPS-1:0] overflow, underflow;

  simt_div_stack #(.N_LANES(N_LANES), .DEPTH(DEPTH), .N_WARPS(N_WARPS), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code), .op_warp(op_warp),
    .op_mask(op_mask), .op_rpc(op_rpc), .q_warp(q_warp), .q_pc(q_pc),
    .tos_mask(tos_mask), .tos_rpc(tos_rpc), .level(level), .all_true(all_true),
    .all_false(all_false), .reconv(reconv), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_LANES-1:0] m;
    logic [N_LANES-1:0] d;
    logic [PC_W-1:0]    r;
  } ment_t;

  ment_t st [N_WARPS][$];
  bit    ovf [N_WARPS];
  bit    unf [N_WARPS];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int w = 0; w < N_WARPS; w++) begin
      st[w].delete();
      st[w].push_back('{m: '1, d: '0, r: '0});
      ovf[w] = 1'b0;
      unf[w] = 1'b0;
    end
  endfunction

  function automatic void model_op(input logic [1:0] c, input int w,
                                   input logic [N_LANES-1:0] m, input logic [PC_W-1:0] r);
    ment_t p;
    ment_t n;
    p = st[w][st[w].size()-1];
    case (c)
      2'b00: if (st[w].size() == DEPTH) ovf[w] = 1'b1;
             else begin
               n.m = m & p.m & ~p.d;
               n.d = p.d | ~p.m;
               n.r = RPC_EN ? r : '0;
               st[w].push_back(n);
             end
      2'b01: if (st[w].size() == 1) unf[w] = 1'b1;
             else void'(st[w].pop_back());
      2'b10: if (st[w].size() == 1) unf[w] = 1'b1;
             else st[w][st[w].size()-1].m = ~p.m & ~p.d;
      default: begin
        st[w].delete();
        st[w].push_back('{m: m, d: '0, r: '0});
        ovf[w] = 1'b0;
        unf[w] = 1'b0;
      end
    endcase
  endfunction

  task automatic check_all();
    int                 w;
    ment_t              t;
    logic [N_WARPS-1:0] eo, eu;
    w = int'(q_warp);
    t = st[w][st[w].size()-1];
    for (int i = 0; i < N_WARPS; i++) begin
      eo[i] = ovf[i];
      eu[i] = unf[i];
    end
    check("tos_mask",  32'(tos_mask),  32'(t.m));
    check("tos_rpc",   32'(tos_rpc),   RPC_EN ? 32'(t.r) : 32'd0);
    check("level",     32'(level),     32'(st[w].size() - 1));
    check("all_true",  32'(all_true),  32'((t.m | t.d) == '1));
    check("all_false", 32'(all_false), 32'((t.m & ~t.d) == '0));
    check("reconv",    32'(reconv),    32'(RPC_EN && st[w].size() > 1 && q_pc == t.r));
    check("overflow",  32'(overflow),  32'(eo));
    check("underflow", 32'(underflow), 32'(eu));
  endtask

  // Drive one operation, check the pre-operation status, then let the edge apply it.
  task automatic step(input bit v, input logic [1:0] c, input int w, input logic [N_LANES-1:0] m,
                      input logic [PC_W-1:0] r, input int qw, input logic [PC_W-1:0] qp);
    @(negedge clk);
    op_valid = v;
    op_code  = c;
    op_warp  = 1'(w);
    op_mask  = m;
    op_rpc   = r;
    q_warp   = 1'(qw);
    q_pc     = qp;
    #1 check_all();
    @(posedge clk);
    if (v) model_op(c, w, m, r);
  endtask

  task automatic look(input int qw, input logic [PC_W-1:0] qp);
    @(negedge clk);
    op_valid = 1'b0;
    q_warp   = 1'(qw);
    q_pc     = qp;
    #1 check_all();
  endtask

  initial begin
    reset = 1'b1;
    op_valid = 1'b0; op_code = 2'b00; op_warp = '0; op_mask = '0; op_rpc = '0;
    q_warp = '0; q_pc = '0;
    model_reset();
    #12 reset = 1'b0;

    look(0, 16'h0);
    check("rst_mask0", 32'(tos_mask), 32'hF);
    check("rst_true0", 32'(all_true), 32'd1);
    check("rst_false0", 32'(all_false), 32'd0);
    look(1, 16'h0);
    check("rst_mask1", 32'(tos_mask), 32'hF);
    check("rst_level1", 32'(level), 32'd0);

    step(1, 2'b00, 0, 4'b0011, 16'h40, 0, 16'h0);
    look(0, 16'h40);
    check("push_mask", 32'(tos_mask), 32'h3);
    check("push_level", 32'(level), 32'd1);
    check("push_true", 32'(all_true), 32'd0);
    check("push_reconv", 32'(reconv), 32'(RPC_EN));
    look(1, 16'h40);
    check("other_warp_mask", 32'(tos_mask), 32'hF);

    step(1, 2'b00, 0, 4'b0001, 16'h50, 0, 16'h0);
    look(0, 16'h0);
    check("nest_mask", 32'(tos_mask), 32'h1);
    step(1, 2'b10, 0, 4'b0000, 16'h0, 0, 16'h0);
    look(0, 16'h0);
    check("comp_mask", 32'(tos_mask), 32'h2);
    step(1, 2'b01, 0, 4'b0000, 16'h0, 0, 16'h0);
    step(1, 2'b01, 0, 4'b0000, 16'h0, 0, 16'h0);
    look(0, 16'h0);
    check("pop_level", 32'(level), 32'd0);
    check("pop_mask", 32'(tos_mask), 32'hF);

    step(1, 2'b00, 0, 4'b0011, 16'h10, 0, 16'h0);
    step(1, 2'b00, 0, 4'b1111, 16'h20, 0, 16'h0);
    look(0, 16'h0);
    check("uniform_true", 32'(all_true), 32'd1);
    step(1, 2'b10, 0, 4'b0000, 16'h0, 0, 16'h0);
    look(0, 16'h0);
    check("uniform_mask", 32'(tos_mask), 32'h0);
    check("uniform_false", 32'(all_false), 32'd1);
    step(1, 2'b01, 0, 4'b0000, 16'h0, 0, 16'h0);
    step(1, 2'b01, 0, 4'b0000, 16'h0, 0, 16'h0);

    for (int i = 0; i < 8; i++) step(1, 2'b00, 1, 4'($urandom), 16'(i), 1, 16'h0);
    look(1, 16'h0);
    check("ovf_level", 32'(level), 32'd7);
    check("ovf_flag", 32'(overflow), 32'h2);
    for (int i = 0; i < 8; i++) step(1, 2'b01, 1, 4'h0, 16'h0, 1, 16'h0);
    look(1, 16'h0);
    check("unf_flag", 32'(underflow), 32'h2);
    step(1, 2'b11, 1, 4'b1111, 16'h0, 1, 16'h0);
    look(1, 16'h0);
    check("init_ovf", 32'(overflow), 32'h0);
    check("init_unf", 32'(underflow), 32'h0);

    for (int i = 0; i < 3; i++) step(1, 2'b00, 0, 4'b0110, 16'h30, 0, 16'h0);
    look(0, 16'h0);
    check("pre_rst_level", 32'(level), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1 check_all();
    check("async_level", 32'(level), 32'd0);
    check("async_mask", 32'(tos_mask), 32'hF);
    #2 reset = 1'b0;
    step(1, 2'b00, 0, 4'b1010, 16'h0, 0, 16'h0);
    look(0, 16'h0);
    check("post_rst_level", 32'(level), 32'd1);

    for (int i = 0; i < 600; i++) begin
      int          sel;
      logic [1:0]  c;
      sel = int'($urandom_range(0, 9));
      c = (sel < 4) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      step(($urandom_range(0, 5) != 0), c, int'($urandom_range(0, 1)), 4'($urandom),
           16'($urandom_range(0, 7)), int'($urandom_range(0, 1)), 16'($urandom_range(0, 7)));
    end
    look(0, 16'h0);
    look(1, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
